// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
// Holds the FSM encoding, the buffered entry layout and the reset defaults.
package fetch_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: power-of-two circular FIFO with zero-latency head read.
// Flush empties it in one cycle and wins over push/pop in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = $bits(fetch_entry_t),
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count,
    output logic             o_empty,
    output logic             o_full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    assign w_pop  = i_pop  & ~o_empty & ~i_flush;
    assign w_push = i_push & ~i_flush & (~o_full | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    // The upstream credit scheme must never push into a full buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(i_push && !i_flush && o_full));

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: issues word fetches under a credit limit, buffers the
// in-order responses and hands (pc, instr) pairs to the decoder.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   BOOT  | single idle cycle after reset release, no requests issued
//   RUN   | normal fetch, every response is live
//   FLUSH | stale responses from before a redirect are still being dropped
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
);

    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        MAX_OUTSTANDING < FIFO_DEPTH || RESET_PC[1:0] != 2'b00) begin : g_bad_params
        $error("instr_fetch_unit: illegal parameter combination");
    end

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_resp_pc;
    logic [CNT_W-1:0] r_live_cnt;
    logic [CNT_W-1:0] r_drop_cnt;
    logic [CNT_W-1:0] w_live_nxt;
    logic [CNT_W-1:0] w_drop_nxt;
    logic [CNT_W-1:0] w_inflight;

    logic             w_credit_ok;
    logic             w_accept;
    logic             w_resp_live;
    logic             w_resp_drop;
    logic             w_push;
    logic             w_pop;

    fetch_entry_t     w_fifo_wdata;
    fetch_entry_t     w_fifo_head;
    logic [FCNT_W-1:0] w_fifo_count;
    logic             w_fifo_empty;
    logic             w_fifo_full;

    // Buffer slots are reserved at issue time so a live response always fits.
    assign w_credit_ok =
        (int'(r_live_cnt) + int'(w_fifo_count) < FIFO_DEPTH) &&
        (int'(r_live_cnt) + int'(r_drop_cnt)  < MAX_OUTSTANDING);

    assign w_accept    = imem_req_valid & imem_req_ready;
    assign w_resp_drop = imem_resp_valid & (r_drop_cnt != '0);
    assign w_resp_live = imem_resp_valid & (r_drop_cnt == '0);
    assign w_push      = w_resp_live & ~redirect_valid;
    assign w_pop       = instr_valid & instr_ready;
    assign w_inflight  = r_drop_cnt + r_live_cnt;

    always_comb begin
        w_state_nxt    = r_state;
        imem_req_valid = 1'b0;
        imem_req_addr  = r_pc;

        if (r_state != BOOT && !redirect_valid && w_credit_ok) begin
            imem_req_valid = 1'b1;
        end

        unique case (r_state)
            BOOT: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                if (redirect_valid && w_drop_nxt != '0) w_state_nxt = FLUSH;
            end
            FLUSH: begin
                if (!redirect_valid && w_drop_nxt == '0) w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    always_comb begin
        w_live_nxt = r_live_cnt;
        w_drop_nxt = r_drop_cnt;

        if (redirect_valid) begin
            // Everything in flight becomes stale; a response landing now is one of them.
            w_live_nxt = '0;
            if (imem_resp_valid && w_inflight != '0) begin
                w_drop_nxt = w_inflight - CNT_W'(1);
            end else begin
                w_drop_nxt = w_inflight;
            end
        end else begin
            if (w_accept && !w_resp_live) begin
                w_live_nxt = r_live_cnt + CNT_W'(1);
            end else if (!w_accept && w_resp_live) begin
                w_live_nxt = r_live_cnt - CNT_W'(1);
            end
            if (w_resp_drop) begin
                w_drop_nxt = r_drop_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= BOOT;
            r_pc       <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_live_cnt <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_live_cnt <= w_live_nxt;
            r_drop_cnt <= w_drop_nxt;
            if (redirect_valid) begin
                r_pc      <= align_word(redirect_pc);
                r_resp_pc <= align_word(redirect_pc);
            end else begin
                if (w_accept)    r_pc      <= r_pc + 32'd4;
                if (w_resp_live) r_resp_pc <= r_resp_pc + 32'd4;
            end
        end
    end

    assign w_fifo_wdata.pc    = r_resp_pc;
    assign w_fifo_wdata.instr = imem_resp_data;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_fifo_wdata),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_rdata (w_fifo_head),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    // An empty buffer presents a NOP at the next PC expected from memory.
    assign instr_valid = ~w_fifo_empty & ~redirect_valid;
    assign instr       = w_fifo_empty ? INSTR_NOP : w_fifo_head.instr;
    assign instr_pc    = w_fifo_empty ? r_resp_pc : w_fifo_head.pc;

    logic w_unused;
    assign w_unused = w_fifo_full;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: an in-order memory model answers
// fetches, expected (pc, instr) pairs are queued at accept and checked at pop.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC        (RST_PC),
        .FIFO_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] exp_addr;
    logic [31:0] prev_addr;
    logic [31:0] last_pc;
    logic [31:0] last_acc_addr;
    logic [31:0] redir_acc_addr;
    logic        prev_vld;
    logic        acc_pending;
    logic        seen_wrap;
    logic        chk_flush_next;
    int          resp_lat;
    int          cyc;
    int          n_acc;
    int          n_pops;
    int          n_tests;
    int          n_fail;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h00A0_0113;
            default:       return {a[31:2], 2'b11} ^ 32'h5A5A_0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: entered at a falling edge, drives inputs, samples 1ns later.
    task automatic step(input logic redir, input logic [31:0] rpc);
        logic [63:0] e;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mem_q[0].addr);
            mem_q.delete(0);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'hDEAD_BEEF;
        end
        #1;
        if (chk_flush_next) begin
            chk("redir_fifo_flushed", instr_valid, 0);
            chk_flush_next = 1'b0;
        end
        if (redir) begin
            chk("redir_no_req", imem_req_valid, 0);
            chk("redir_no_pop", instr_valid, 0);
            exp_q.delete();
            exp_addr       = {rpc[31:2], 2'b00};
            acc_pending    = 1'b1;
            redir_acc_addr = 32'hDEAD_BEEF;
        end else if (prev_vld) begin
            chk("req_hold_valid", imem_req_valid, 1);
            chk("req_hold_addr", imem_req_addr, prev_addr);
        end
        chk("credit", exp_q.size() <= DEPTH, 1);
        if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, exp_addr);
            if (acc_pending) begin
                redir_acc_addr = imem_req_addr;
                acc_pending    = 1'b0;
            end
            if (n_acc > 0 && imem_req_addr == 32'h0 && last_acc_addr == 32'hFFFF_FFFC)
                seen_wrap = 1'b1;
            last_acc_addr = imem_req_addr;
            mem_q.push_back('{addr: imem_req_addr, due: cyc + resp_lat});
            exp_q.push_back({exp_addr, mem_word(exp_addr)});
            exp_addr = exp_addr + 32'd4;
            n_acc++;
        end
        if (instr_valid && instr_ready) begin
            chk("sb_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("instr_pc", instr_pc, e[63:32]);
                chk("instr", instr, e[31:0]);
            end
            last_pc = instr_pc;
            n_pops++;
        end
        prev_vld  = imem_req_valid && !imem_req_ready;
        prev_addr = imem_req_addr;
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n0;
        logic found;

        rst = 1'b1;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
        exp_addr = RST_PC; prev_addr = 32'h0; last_pc = 32'h0; last_acc_addr = 32'h0;
        redir_acc_addr = 32'hDEAD_BEEF; prev_vld = 1'b0; acc_pending = 1'b0;
        seen_wrap = 1'b0; chk_flush_next = 1'b0; resp_lat = 1; cyc = 0;
        n_acc = 0; n_pops = 0; n_tests = 0; n_fail = 0;

        #12;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr_nop", instr, INSTR_NOP);
        chk("rst_instr_pc", instr_pc, RST_PC);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("boot_idle", imem_req_valid, 0);
        @(negedge clk);

        // 1: straight-line fetch, 1-cycle memory
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        repeat (12) step(1'b0, 32'h0);
        chk("t1_pops", n_pops >= 3, 1);

        // 2: decoder back-pressure
        instr_ready = 1'b0;
        repeat (8) step(1'b0, 32'h0);
        chk("t2_req_low", imem_req_valid, 0);
        chk("t2_buffered", exp_q.size(), DEPTH);
        instr_ready = 1'b1;
        repeat (10) step(1'b0, 32'h0);

        // 3: redirect with two requests in flight
        imem_req_ready = 1'b0;
        repeat (4) step(1'b0, 32'h0);
        step(1'b1, 32'h0000_0010);
        resp_lat = 5;
        imem_req_ready = 1'b1;
        n0 = n_acc;
        k = 0;
        while (n_acc < n0 + 2 && k < 20) begin step(1'b0, 32'h0); k++; end
        chk("t3_two_inflight", n_acc - n0, 2);
        step(1'b1, 32'h0000_0100);
        n0 = n_pops;
        k = 0;
        while (n_pops == n0 && k < 40) begin step(1'b0, 32'h0); k++; end
        chk("t3_pop_seen", n_pops > n0, 1);
        chk("t3_first_pc", last_pc, 32'h0000_0100);
        chk("t3_next_addr", redir_acc_addr, 32'h0000_0100);

        // 4: redirect colliding with a response and a pending pop
        resp_lat = 2;
        repeat (6) step(1'b0, 32'h0);
        found = 1'b0;
        k = 0;
        while (!found && k < 50) begin
            if (instr_valid && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                found = 1'b1;
                step(1'b1, 32'h0000_0203);
                chk_flush_next = 1'b1;
            end else begin
                step(1'b0, 32'h0);
            end
            k++;
        end
        chk("t4_trigger", found, 1);
        repeat (10) step(1'b0, 32'h0);
        chk("t4_next_addr", redir_acc_addr, 32'h0000_0200);

        // 5: address wrap
        resp_lat = 1;
        step(1'b1, 32'hFFFF_FFFC);
        repeat (10) step(1'b0, 32'h0);
        chk("t5_first_addr", redir_acc_addr, 32'hFFFF_FFFC);
        chk("t5_wrap", seen_wrap, 1);

        // 6: reset in the middle of a stream
        k = 0;
        while (!instr_valid && k < 30) begin step(1'b0, 32'h0); k++; end
        chk("t6_instr_valid_before", instr_valid, 1);
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t6_instr_valid", instr_valid, 0);
        chk("t6_req_valid", imem_req_valid, 0);
        chk("t6_instr_nop", instr, INSTR_NOP);
        mem_q.delete();
        exp_q.delete();
        exp_addr       = RST_PC;
        prev_vld       = 1'b0;
        acc_pending    = 1'b1;
        redir_acc_addr = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 chk("t6_boot_idle", imem_req_valid, 0);
        @(negedge clk);
        step(1'b0, 32'h0);
        chk("t6_first_addr", redir_acc_addr, RST_PC);
        repeat (10) step(1'b0, 32'h0);

        // drain everything still expected
        imem_req_ready = 1'b0;
        k = 0;
        while (exp_q.size() > 0 && k < 30) begin step(1'b0, 32'h0); k++; end
        chk("final_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
